// File: rtl/op_slot_sequencer.sv
// ---------------------------------------------------------------------------
// op_slot_sequencer
//
// Purpose:
//   Per-sample operator slot scheduler. Each sample_clk_en pulse starts a frame
//   in which every (bank, operator) slot is offered in turn to the shared
//   operator datapath over a valid/ready handshake. After each accepted slot
//   (except the last) SLOT_GAP idle cycles are inserted. Sample pulses that
//   arrive while a frame is still running are dropped and flagged in a sticky
//   overrun bit.
//
// Parameters:
//   NUM_BANKS         register banks per sample frame (>=1)
//   NUM_OPS_PER_BANK  operator slots per bank (>=1)
//   SLOT_GAP          idle cycles after each accepted slot except the last (>=0)
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   sample_clk_en  in   1-cycle sample-rate pulse
//   op_ready       in   datapath can accept a slot this cycle
//   slot_valid     out  slot request; bank_num/op_num are valid
//   bank_num       out  current bank
//   op_num         out  current operator
//   frame_active   out  high while a frame is being issued (ISSUE or GAP)
//   frame_done     out  1-cycle pulse after the final slot is accepted
//   overrun        out  sticky: sample pulse arrived while frame_active
//   overrun_clr    in   clears overrun (an overrun event in the same cycle wins)
// ---------------------------------------------------------------------------
module op_slot_sequencer #(
   parameter  int NUM_BANKS        = 2,
   parameter  int NUM_OPS_PER_BANK = 18,
   parameter  int SLOT_GAP         = 2,
   localparam int BW = (NUM_BANKS > 1)        ? $clog2(NUM_BANKS)        : 1,
   localparam int OW = (NUM_OPS_PER_BANK > 1) ? $clog2(NUM_OPS_PER_BANK) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          sample_clk_en,
   input  logic          op_ready,
   output logic          slot_valid,
   output logic [BW-1:0] bank_num,
   output logic [OW-1:0] op_num,
   output logic          frame_active,
   output logic          frame_done,
   output logic          overrun,
   input  logic          overrun_clr
);

   localparam int GW = (SLOT_GAP > 0) ? $clog2(SLOT_GAP + 1) : 1;

   localparam logic [BW-1:0] BANK_LAST = BW'(NUM_BANKS - 1);
   localparam logic [OW-1:0] OP_LAST   = OW'(NUM_OPS_PER_BANK - 1);
   // Value of the gap counter in the final idle cycle of a gap.
   localparam logic [GW-1:0] GAP_LAST  = GW'((SLOT_GAP > 0) ? (SLOT_GAP - 1) : 0);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] bank_q, bank_d;
   logic [OW-1:0] op_q, op_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic          slot_valid_q, slot_valid_d;
   logic          frame_active_q, frame_active_d;
   logic          frame_done_q, frame_done_d;
   logic          overrun_q, overrun_d;

   logic          accept;
   logic          last_accept;

   // slot_valid_q is high exactly when state_q is ISSUE, so accept only
   // happens in ISSUE; op_ready outside of it is ignored.
   assign accept = slot_valid_q & op_ready;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q        <= IDLE;
         bank_q         <= '0;
         op_q           <= '0;
         gap_cnt_q      <= '0;
         slot_valid_q   <= 1'b0;
         frame_active_q <= 1'b0;
         frame_done_q   <= 1'b0;
         overrun_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         bank_q         <= bank_d;
         op_q           <= op_d;
         gap_cnt_q      <= gap_cnt_d;
         slot_valid_q   <= slot_valid_d;
         frame_active_q <= frame_active_d;
         frame_done_q   <= frame_done_d;
         overrun_q      <= overrun_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      bank_d      = bank_q;
      op_d        = op_q;
      gap_cnt_d   = gap_cnt_q;
      last_accept = 1'b0;

      case (state_q)
         IDLE: begin
            if (sample_clk_en) begin
               state_d = ISSUE;
               bank_d  = '0;
               op_d    = '0;
            end
         end

         ISSUE: begin
            if (accept) begin
               if (op_q == OP_LAST) begin
                  op_d = '0;
                  if (bank_q == BANK_LAST) begin
                     // Final slot of the frame: back to IDLE with indices cleared.
                     bank_d      = '0;
                     last_accept = 1'b1;
                  end else begin
                     bank_d = bank_q + 1'b1;
                  end
               end else begin
                  op_d = op_q + 1'b1;
               end

               if (last_accept) begin
                  state_d = IDLE;
               end else if (SLOT_GAP > 0) begin
                  state_d   = GAP;
                  gap_cnt_d = '0;
               end
               // SLOT_GAP == 0: stay in ISSUE for back-to-back slots.
            end
         end

         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               state_d = ISSUE;
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = IDLE;
            bank_d  = '0;
            op_d    = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Output logic (next values of the registered outputs)
   // ------------------------------------------------------------------------
   always_comb begin
      slot_valid_d   = (state_d == ISSUE);
      frame_active_d = (state_d != IDLE);
      frame_done_d   = last_accept;

      // A pulse during a running frame is dropped by the FSM (IDLE is the only
      // state that reacts to it) and recorded here. Setting beats clearing.
      overrun_d = overrun_q;
      if (sample_clk_en && frame_active_q) begin
         overrun_d = 1'b1;
      end else if (overrun_clr) begin
         overrun_d = 1'b0;
      end
   end

   assign slot_valid   = slot_valid_q;
   assign bank_num     = bank_q;
   assign op_num       = op_q;
   assign frame_active = frame_active_q;
   assign frame_done   = frame_done_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_op_slot_sequencer.sv
// ---------------------------------------------------------------------------
// tb_op_slot_sequencer
//
// Directed, table-driven bench. Two instances share all inputs: "dut" uses the
// default parameters, "dut_g0" uses SLOT_GAP=0 for the back-to-back frame.
// Outputs are sampled 1 time unit after the rising edge; inputs for the cycle
// are driven at that same point. Cycle numbering within a table run starts at
// 0; a sample_clk_en driven in cycle N produces the first slot in cycle N+1.
// ---------------------------------------------------------------------------
module tb_op_slot_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       sample_clk_en;
   logic       op_ready;
   logic       overrun_clr;

   logic       slot_valid, frame_active, frame_done, overrun;
   logic [0:0] bank_num;
   logic [4:0] op_num;

   logic       slot_valid_g0, frame_active_g0, frame_done_g0, overrun_g0;
   logic [0:0] bank_num_g0;
   logic [4:0] op_num_g0;

   op_slot_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .sample_clk_en (sample_clk_en),
      .op_ready      (op_ready),
      .slot_valid    (slot_valid),
      .bank_num      (bank_num),
      .op_num        (op_num),
      .frame_active  (frame_active),
      .frame_done    (frame_done),
      .overrun       (overrun),
      .overrun_clr   (overrun_clr)
   );

   op_slot_sequencer #(
      .NUM_BANKS        (2),
      .NUM_OPS_PER_BANK (18),
      .SLOT_GAP         (0)
   ) dut_g0 (
      .clk           (clk),
      .reset         (reset),
      .sample_clk_en (sample_clk_en),
      .op_ready      (op_ready),
      .slot_valid    (slot_valid_g0),
      .bank_num      (bank_num_g0),
      .op_num        (op_num_g0),
      .frame_active  (frame_active_g0),
      .frame_done    (frame_done_g0),
      .overrun       (overrun_g0),
      .overrun_clr   (overrun_clr)
   );

   // One record per cycle: inputs driven in that cycle plus the outputs
   // expected to be visible in that cycle.
   typedef struct {
      logic en;
      logic rdy;
      logic v;
      int   b;
      int   o;
      logic act;
      logic done;
      logic ovr;
      logic chk0;
      logic v0;
      int   b0;
      int   o0;
      logic done0;
   } vec_t;

   vec_t tv [200];
   int   tv_len;

   int nvec = 0;
   int nerr = 0;
   int tc   = 0;

   task automatic chk(input string nm, input int got, input int exp);
      nvec++;
      if (got != exp) begin
         nerr++;
         $display("FAIL %s (cycle %0d): got %0d, expected %0d", nm, tc, got, exp);
      end
   endtask

   task automatic step(input logic en, input logic rdy, input logic clr, input logic rst);
      sample_clk_en = en;
      op_ready      = rdy;
      overrun_clr   = clr;
      reset         = rst;
      @(posedge clk);
      #1;
      tc++;
   endtask

   // Expected frame for the default instance, from the closed-form timing:
   // slot k presented at 1+3k (+stall_len for slots after the stalled one),
   // the stalled slot held for stall_len extra cycles, frame_done at
   // 107+stall_len. Cycles before 'base' are idle. ovr_at<0 means no second
   // pulse. The SLOT_GAP=0 instance is only checked on plain frames.
   task automatic fill(input int base, input int stall_k, input int stall_len,
                       input int ovr_at, input int len);
      tv_len = len;
      for (int c = 0; c < len; c++) begin
         int   rel;
         int   p;
         int   h;
         vec_t r;
         rel     = c - base;
         r       = '{default: 0};
         r.rdy   = 1'b1;
         r.en    = (rel == 0) || (ovr_at >= 0 && rel == ovr_at);
         for (int k = 0; k < 36; k++) begin
            p = 1 + 3 * k + ((k > stall_k) ? stall_len : 0);
            h = (k == stall_k) ? stall_len : 0;
            if (rel >= p && rel <= p + h) begin
               r.v = 1'b1;
               r.b = k / 18;
               r.o = k % 18;
               if (rel < p + h) r.rdy = 1'b0;
            end
         end
         r.act   = (rel >= 1) && (rel <= 106 + stall_len);
         r.done  = (rel == 107 + stall_len);
         r.ovr   = (ovr_at >= 0) && (rel > ovr_at);
         r.chk0  = (stall_len == 0) && (ovr_at < 0);
         r.v0    = (rel >= 1) && (rel <= 36);
         r.b0    = (rel - 1) / 18;
         r.o0    = (rel - 1) % 18;
         r.done0 = (rel == 37);
         tv[c]   = r;
      end
   endtask

   task automatic run_table(input string tag);
      tc = 0;
      for (int c = 0; c < tv_len; c++) begin
         chk({tag, ".slot_valid"},   int'(slot_valid),   int'(tv[c].v));
         chk({tag, ".frame_active"}, int'(frame_active), int'(tv[c].act));
         chk({tag, ".frame_done"},   int'(frame_done),   int'(tv[c].done));
         chk({tag, ".overrun"},      int'(overrun),      int'(tv[c].ovr));
         if (tv[c].v) begin
            chk({tag, ".bank_num"}, int'(bank_num), tv[c].b);
            chk({tag, ".op_num"},   int'(op_num),   tv[c].o);
         end
         if (tv[c].chk0) begin
            chk({tag, ".g0.slot_valid"},   int'(slot_valid_g0),   int'(tv[c].v0));
            chk({tag, ".g0.frame_active"}, int'(frame_active_g0), int'(tv[c].v0));
            chk({tag, ".g0.frame_done"},   int'(frame_done_g0),   int'(tv[c].done0));
            chk({tag, ".g0.overrun"},      int'(overrun_g0),      0);
            if (tv[c].v0) begin
               chk({tag, ".g0.bank_num"}, int'(bank_num_g0), tv[c].b0);
               chk({tag, ".g0.op_num"},   int'(op_num_g0),   tv[c].o0);
            end
         end
         step(tv[c].en, tv[c].rdy, 1'b0, 1'b0);
      end
   endtask

   initial begin
      reset         = 1'b1;
      sample_clk_en = 1'b0;
      op_ready      = 1'b0;
      overrun_clr   = 1'b0;
      repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);

      // Reset state
      chk("rst.slot_valid",   int'(slot_valid),   0);
      chk("rst.bank_num",     int'(bank_num),     0);
      chk("rst.op_num",       int'(op_num),       0);
      chk("rst.frame_active", int'(frame_active), 0);
      chk("rst.frame_done",   int'(frame_done),   0);
      chk("rst.overrun",      int'(overrun),      0);

      // Plain frame, pulse at cycle 10 (both instances)
      fill(10, -1, 0, -1, 125);
      run_table("plain");

      // op_ready low for 5 cycles while slot (0,3) is presented
      fill(2, 3, 5, -1, 120);
      run_table("stall");

      // Second pulse 50 cycles into the frame
      fill(2, -1, 0, 50, 115);
      run_table("ovr");

      // overrun_clr alone clears on the next cycle
      step(1'b0, 1'b1, 1'b1, 1'b0);
      chk("clr.overrun", int'(overrun), 0);

      // New frame; at cycle 5 an overrun event coincides with overrun_clr
      tc = 0;
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("f5.first_valid", int'(slot_valid), 1);
      while (tc < 5) step(1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      chk("setwins.overrun", int'(overrun), 1);

      // Reset pulsed while slot (1,4) is presented
      while (tc < 67) step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("r14.slot_valid", int'(slot_valid), 1);
      chk("r14.bank_num",   int'(bank_num),   1);
      chk("r14.op_num",     int'(op_num),     4);
      step(1'b0, 1'b1, 1'b0, 1'b1);
      chk("abort.slot_valid",   int'(slot_valid),   0);
      chk("abort.bank_num",     int'(bank_num),     0);
      chk("abort.op_num",       int'(op_num),       0);
      chk("abort.frame_active", int'(frame_active), 0);
      chk("abort.frame_done",   int'(frame_done),   0);
      for (int i = 0; i < 45; i++) begin
         step(1'b0, 1'b1, 1'b0, 1'b0);
         if (frame_done || slot_valid) chk("abort.quiet", 1, 0);
      end

      // Restart from (0,0), then pulse in the frame_done cycle
      tc = 0;
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("restart.slot_valid", int'(slot_valid), 1);
      chk("restart.bank_num",   int'(bank_num),   0);
      chk("restart.op_num",     int'(op_num),     0);
      while (tc < 107) step(1'b0, 1'b1, 1'b0, 1'b0);
      chk("coinc.frame_done",   int'(frame_done),   1);
      chk("coinc.frame_active", int'(frame_active), 0);
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("coinc.slot_valid",   int'(slot_valid),   1);
      chk("coinc.bank_num",     int'(bank_num),     0);
      chk("coinc.op_num",       int'(op_num),       0);
      chk("coinc.frame_active", int'(frame_active), 1);
      chk("coinc.frame_done2",  int'(frame_done),   0);
      chk("coinc.overrun",      int'(overrun),      0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
